// File: rtl/wisc_pkg.sv
// Shared fetch-stage types and default constants for the WISC core.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package wisc_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        FULL  = 2'd2,
        HALT  = 2'd3
    } if_state_t;

    localparam logic [15:0] RESET_PC_DEF  = 16'h0000;
    localparam logic [15:0] NOP_INSTR_DEF = 16'h0000;
    localparam logic [3:0]  HLT_OP_DEF    = 4'hF;

    // True when the word carries the halt opcode in its top nibble.
    function automatic logic is_hlt(input logic [15:0] word, input logic [3:0] op);
        return word[15:12] == op;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry holding register for an instruction word and its PC+1 while ID stalls.
// Latency: 1 cycle load-to-full; contents readable combinationally while full.
// Backpressure: none internally; the owner must not load while full.
//
// Ports: load captures in_instr/in_pc and sets full; drain or clear empties it
// (clear and drain win over load); out_instr/out_pc are the held entry.
module fetch_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_pc,
    output logic        full,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc
);

    logic        full_q,  full_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_q,    pc_d;

    always_comb begin
        full_d  = full_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear || drain) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d  = 1'b1;
            instr_d = in_instr;
            pc_d    = in_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            instr_q <= 16'h0000;
            pc_q    <= 16'h0000;
        end else begin
            full_q  <= full_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign full      = full_q;
    assign out_instr = instr_q;
    assign out_pc    = pc_q;

endmodule

// File: rtl/if_unit.sv
// Instruction fetch stage: issues word-address requests and presents instr/PC+1 to ID.
// Latency: 1 cycle from an accepted request (imem_req & imem_rdy) to instr_valid.
// Backpressure: stall freezes the outputs; one in-flight word parks in fetch_buf and requests stop.
//
// Ports: clk/rst_n (async active-low); PC_update_done/PC_src/PC_update redirect from EX;
// stall from ID; imem_req/imem_addr/imem_rdy/imem_data to instruction memory;
// instr/PC_out/instr_valid to ID; halted once a HLT has been delivered.
module if_unit
    import wisc_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter logic [3:0]  HLT_OP    = HLT_OP_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PC_update_done,
    input  logic        PC_src,
    input  logic [15:0] PC_update,
    input  logic        stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    output logic [15:0] PC_out,
    output logic        instr_valid,
    output logic        halted
);

    if_state_t   state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] tgt_q, tgt_d;          // redirect target parked while a dropped fetch is outstanding
    logic        discard_q, discard_d;  // outstanding fetch belongs to the old path
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic        instr_vld_q, instr_vld_d;

    logic        buf_load, buf_drain, buf_clear, buf_full;
    logic [15:0] buf_instr_dat, buf_pc_dat;

    logic        redirect;
    logic        out_free;
    logic [15:0] pc_inc;

    assign redirect = PC_update_done & PC_src;
    // The output slot can take a word if it is empty or ID is consuming it this cycle.
    assign out_free = !instr_vld_q || !stall;
    assign pc_inc   = pc_q + 16'd1;

    // Gated by rst_n so no request is visible while reset is held.
    assign imem_req  = rst_n && ((state_q == FETCH) || (state_q == WAIT));
    assign imem_addr = pc_q;

    fetch_buf u_fetch_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (buf_load),
        .drain     (buf_drain),
        .clear     (buf_clear),
        .in_instr  (imem_data),
        .in_pc     (pc_inc),
        .full      (buf_full),
        .out_instr (buf_instr_dat),
        .out_pc    (buf_pc_dat)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        discard_d   = discard_q;
        instr_d     = instr_q;
        pc_out_d    = pc_out_q;
        instr_vld_d = instr_vld_q;
        buf_load    = 1'b0;
        buf_drain   = 1'b0;
        buf_clear   = 1'b0;

        // ID consumed the current word; show a bubble unless refilled below.
        if (instr_vld_q && !stall) begin
            instr_vld_d = 1'b0;
            instr_d     = NOP_INSTR;
        end

        if (redirect) begin
            instr_vld_d = 1'b0;
            instr_d     = NOP_INSTR;
            buf_clear   = 1'b1;
            if (imem_req && !imem_rdy) begin
                // Memory still owes us a word at the old address: keep the
                // request stable, drop the word when it arrives, then jump.
                state_d   = WAIT;
                discard_d = 1'b1;
                tgt_d     = PC_update;
            end else begin
                state_d   = FETCH;
                discard_d = 1'b0;
                pc_d      = PC_update;
            end
        end else begin
            case (state_q)
                FETCH, WAIT: begin
                    if (imem_rdy) begin
                        if (discard_q) begin
                            state_d   = FETCH;
                            discard_d = 1'b0;
                            pc_d      = tgt_q;
                        end else begin
                            pc_d = pc_inc;
                            if (out_free && !buf_full) begin
                                instr_d     = imem_data;
                                pc_out_d    = pc_inc;
                                instr_vld_d = 1'b1;
                                state_d     = is_hlt(imem_data, HLT_OP) ? HALT : FETCH;
                            end else begin
                                buf_load = 1'b1;
                                state_d  = FULL;
                            end
                        end
                    end else begin
                        state_d = WAIT;
                    end
                end
                FULL: begin
                    if (!stall) begin
                        instr_d     = buf_instr_dat;
                        pc_out_d    = buf_pc_dat;
                        instr_vld_d = 1'b1;
                        buf_drain   = 1'b1;
                        state_d     = is_hlt(buf_instr_dat, HLT_OP) ? HALT : FETCH;
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            tgt_q       <= RESET_PC;
            discard_q   <= 1'b0;
            instr_q     <= NOP_INSTR;
            pc_out_q    <= 16'h0000;
            instr_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            discard_q   <= discard_d;
            instr_q     <= instr_d;
            pc_out_q    <= pc_out_d;
            instr_vld_q <= instr_vld_d;
        end
    end

    assign instr       = instr_q;
    assign PC_out      = pc_out_q;
    assign instr_valid = instr_vld_q;
    assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_if_unit.sv
// Directed self-checking bench for if_unit.
// Latency: inputs change 1 time unit after a rising edge; outputs sampled 1 unit later.
// Backpressure: stall and imem_rdy driven from the directed sequence below.
module tb_if_unit;

    logic        clk;
    logic        rst_n;
    logic        pc_update_done;
    logic        pc_src;
    logic [15:0] pc_update;
    logic        stall;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic [15:0] pc_out;
    logic        instr_valid;
    logic        halted;

    logic [15:0] hlt_addr;
    int          vectors;
    int          errors;

    // Memory model: word at address a is 16'h1000 + a, except one halt word.
    assign imem_data = (imem_addr == hlt_addr) ? 16'hF000 : 16'(16'h1000 + imem_addr);

    if_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .PC_update_done (pc_update_done),
        .PC_src         (pc_src),
        .PC_update      (pc_update),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdy       (imem_rdy),
        .imem_data      (imem_data),
        .instr          (instr),
        .PC_out         (pc_out),
        .instr_valid    (instr_valid),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; inputs are then driven and outputs sampled mid-cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [15:0] e_instr,
                           input logic [15:0] e_pc, input logic e_vld);
        chk({tag, ".instr"},  instr,                e_instr);
        chk({tag, ".pc_out"}, pc_out,               e_pc);
        chk({tag, ".valid"},  {15'd0, instr_valid}, {15'd0, e_vld});
    endtask

    task automatic chk_req(input string tag, input logic e_req, input logic [15:0] e_addr);
        chk({tag, ".req"},  {15'd0, imem_req}, {15'd0, e_req});
        chk({tag, ".addr"}, imem_addr,         e_addr);
    endtask

    initial begin
        vectors        = 0;
        errors         = 0;
        hlt_addr       = 16'hAAAA;
        rst_n          = 1'b0;
        pc_update_done = 1'b0;
        pc_src         = 1'b0;
        pc_update      = 16'h0000;
        stall          = 1'b0;
        imem_rdy       = 1'b1;

        // Reset values, with imem_rdy high and ignored.
        #2;
        chk_out("rst", 16'h0000, 16'h0000, 1'b0);
        chk_req("rst", 1'b0, 16'h0000);
        chk("rst.halted", {15'd0, halted}, 16'h0000);
        cyc();
        cyc();
        chk_req("rst_hold", 1'b0, 16'h0000);
        chk("rst_hold.valid", {15'd0, instr_valid}, 16'h0000);

        // Back-to-back fetch after reset release.
        rst_n = 1'b1;
        #1;
        chk_req("rel", 1'b1, 16'h0000);
        cyc();
        chk_out("b2b0", 16'h1000, 16'h0001, 1'b1);
        chk_req("b2b0", 1'b1, 16'h0001);
        cyc();
        chk_out("b2b1", 16'h1001, 16'h0002, 1'b1);
        chk_req("b2b1", 1'b1, 16'h0002);
        cyc();
        cyc();
        chk_out("b2b3", 16'h1003, 16'h0004, 1'b1);

        // Two stall cycles: 1003 held, word 4 parked, no requests.
        stall = 1'b1;
        cyc();
        chk_out("stall1", 16'h1003, 16'h0004, 1'b1);
        chk("stall1.req", {15'd0, imem_req}, 16'h0000);
        cyc();
        chk_out("stall2", 16'h1003, 16'h0004, 1'b1);
        chk("stall2.req", {15'd0, imem_req}, 16'h0000);
        stall = 1'b0;
        cyc();
        chk_out("unstall", 16'h1004, 16'h0005, 1'b1);
        chk_req("unstall", 1'b1, 16'h0005);

        // imem_rdy low for 3 cycles at address 5.
        imem_rdy = 1'b0;
        #1;
        chk_req("wait_a", 1'b1, 16'h0005);
        cyc();
        chk_req("wait_b", 1'b1, 16'h0005);
        chk("wait_b.valid", {15'd0, instr_valid}, 16'h0000);
        chk("wait_b.instr", instr, 16'h0000);
        cyc();
        chk_req("wait_c", 1'b1, 16'h0005);
        cyc();
        imem_rdy = 1'b1;
        chk_req("wait_d", 1'b1, 16'h0005);
        cyc();
        chk_out("wait_dlv", 16'h1005, 16'h0006, 1'b1);
        imem_rdy = 1'b0;
        cyc();
        chk("wait_single.valid", {15'd0, instr_valid}, 16'h0000);
        imem_rdy = 1'b1;
        cyc();
        chk_out("w6", 16'h1006, 16'h0007, 1'b1);

        // Redirect to 0x0040 while waiting on address 7.
        imem_rdy = 1'b0;
        cyc();
        chk_req("w7", 1'b1, 16'h0007);
        pc_update_done = 1'b1;
        pc_src         = 1'b1;
        pc_update      = 16'h0040;
        cyc();
        pc_update_done = 1'b0;
        pc_src         = 1'b0;
        chk_out("redir_w", 16'h0000, 16'h0007, 1'b0);
        chk_req("redir_w", 1'b1, 16'h0007);
        imem_rdy = 1'b1;
        cyc();
        chk("drop7.valid", {15'd0, instr_valid}, 16'h0000);
        chk_req("drop7", 1'b1, 16'h0040);
        cyc();
        chk_out("tgt40", 16'h1040, 16'h0041, 1'b1);

        // PC_update_done without PC_src has no effect.
        pc_update_done = 1'b1;
        pc_update      = 16'h0099;
        cyc();
        pc_update_done = 1'b0;
        chk_out("nosrc", 16'h1041, 16'h0042, 1'b1);
        chk_req("nosrc", 1'b1, 16'h0042);

        // Wrap at 16'hFFFF, then halt on the word at 0.
        pc_update_done = 1'b1;
        pc_src         = 1'b1;
        pc_update      = 16'hFFFF;
        cyc();
        pc_update_done = 1'b0;
        pc_src         = 1'b0;
        hlt_addr       = 16'h0000;
        chk_req("jmp_ffff", 1'b1, 16'hFFFF);
        chk("jmp_ffff.valid", {15'd0, instr_valid}, 16'h0000);
        cyc();
        chk_out("wrap", 16'h0FFF, 16'h0000, 1'b1);
        chk_req("wrap", 1'b1, 16'h0000);
        cyc();
        chk_out("hlt", 16'hF000, 16'h0001, 1'b1);
        chk("hlt.halted", {15'd0, halted}, 16'h0001);
        chk("hlt.req", {15'd0, imem_req}, 16'h0000);
        cyc();
        chk("hlt2.halted", {15'd0, halted}, 16'h0001);
        chk("hlt2.req", {15'd0, imem_req}, 16'h0000);
        pc_update_done = 1'b1;
        pc_src         = 1'b1;
        pc_update      = 16'h0010;
        cyc();
        pc_update_done = 1'b0;
        pc_src         = 1'b0;
        hlt_addr       = 16'hAAAA;
        chk("unhalt.halted", {15'd0, halted}, 16'h0000);
        chk_req("unhalt", 1'b1, 16'h0010);
        cyc();
        chk_out("r10", 16'h1010, 16'h0011, 1'b1);

        // Reset asserted while both stalled and waiting.
        stall    = 1'b1;
        imem_rdy = 1'b0;
        cyc();
        chk_out("pre_rst", 16'h1010, 16'h0011, 1'b1);
        chk_req("pre_rst", 1'b1, 16'h0011);
        rst_n    = 1'b0;
        imem_rdy = 1'b1;
        #1;
        chk_out("mid_rst", 16'h0000, 16'h0000, 1'b0);
        chk_req("mid_rst", 1'b0, 16'h0000);
        chk("mid_rst.halted", {15'd0, halted}, 16'h0000);
        cyc();
        chk_req("mid_rst_hold", 1'b0, 16'h0000);
        rst_n = 1'b1;
        stall = 1'b0;
        #1;
        chk_req("rel2", 1'b1, 16'h0000);
        cyc();
        chk_out("rel2", 16'h1000, 16'h0001, 1'b1);

        // Redirect beats stall and flushes the parked word.
        stall = 1'b1;
        cyc();
        chk("park.req", {15'd0, imem_req}, 16'h0000);
        pc_update_done = 1'b1;
        pc_src         = 1'b1;
        pc_update      = 16'h0020;
        cyc();
        pc_update_done = 1'b0;
        pc_src         = 1'b0;
        chk_out("redir_stall", 16'h0000, 16'h0001, 1'b0);
        chk_req("redir_stall", 1'b1, 16'h0020);
        stall = 1'b0;
        cyc();
        chk_out("flushed", 16'h1020, 16'h0021, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
